dm_cache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data/instruction cache placed between the pipelined MIPS core and the 128-bit slow memory. It serves word-wide core accesses in one cycle on a hit. On a miss it stalls the core, writes back a dirty victim line if present, and refills the line through the memory's read/write/ready handshake. Each core memory port gets one instance.

---
 rtl/dm_cache_ctrl_if.sv | 29 ++
 rtl/dm_cache_ctrl.sv | 123 ++++++++++++
 tb/tb_dm_cache_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_ctrl_if.sv
// Core/memory bus bundle for one direct-mapped cache controller.
//   slave  : the cache controller (takes core requests, issues line requests to memory)
//   master : the environment (core request side plus the slow line memory)
// Core side  : proc_read/proc_write/proc_addr/proc_wdata in, proc_rdata/proc_stall out
// Memory side: mem_read/mem_write/mem_addr/mem_wdata out, mem_rdata/mem_ready in
interface dm_cache_ctrl_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller between the core
// and a 128-bit line memory. Hits complete in the request cycle; misses stall
// the core, write back a dirty victim if needed, then refill the line.
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset
//   bus   : dm_cache_ctrl_if.slave (core request port + memory line port)
module dm_cache_ctrl #(
    parameter int unsigned NUM_BLOCKS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dm_cache_ctrl_if.slave bus
);
    localparam int unsigned INDEX_W = $clog2(NUM_BLOCKS);
    localparam int unsigned TAG_W   = 30 - INDEX_W - 2;
    localparam int unsigned LINE_W  = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned MADDR_W = 28;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    state_e                state_q;
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_q [NUM_BLOCKS];
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [MADDR_W-1:0]    mem_addr_q;
    logic [LINE_W-1:0]     mem_wdata_q;

    logic [INDEX_W-1:0]    idx;
    logic [TAG_W-1:0]      tag;
    logic [6:0]            bit_off;
    logic                  req;
    logic                  hit;

    // Address decode and tag compare
    assign idx     = bus.proc_addr[INDEX_W+1:2];
    assign tag     = bus.proc_addr[29:INDEX_W+2];
    assign bit_off = {bus.proc_addr[1:0], 5'b0_0000};
    assign req     = bus.proc_read | bus.proc_write;
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);

    // Core-facing outputs resolve in the request cycle
    assign bus.proc_rdata = data_q[idx][bit_off +: WORD_W];
    assign bus.proc_stall = (state_q != COMPARE) || (req && !hit);

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Controller FSM with registered memory requests and line status bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COMPARE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                COMPARE: begin
                    if (req && hit) begin
                        if (bus.proc_write) begin
                            dirty_q[idx] <= 1'b1;
                        end
                    end else if (req) begin
                        // dirty implies valid, but both are tested so a stale dirty bit can never evict
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx};
                            mem_wdata_q <= data_q[idx];
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= bus.proc_addr[29:2];
                        end
                    end
                end
                WRITEBACK: begin
                    // dirty stays set here; the refill clears it
                    if (bus.mem_ready) begin
                        state_q     <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= bus.proc_addr[29:2];
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        state_q      <= COMPARE;
                        mem_read_q   <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: begin
                    state_q <= COMPARE;
                end
            endcase
        end
    end

    // Line payload and tags carry no reset; valid_q qualifies them
    always_ff @(posedge clk) begin
        if (state_q == ALLOCATE && bus.mem_ready) begin
            data_q[idx] <= bus.mem_rdata;
            tag_q[idx]  <= tag;
        end else if (state_q == COMPARE && hit && bus.proc_write) begin
            data_q[idx][bit_off +: WORD_W] <= bus.proc_wdata;
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios followed by random
// accesses, checked against an abstract cache + memory model.
module tb_dm_cache_ctrl;
    logic clk;
    logic rst_n;

    dm_cache_ctrl_if bus ();

    dm_cache_ctrl #(.NUM_BLOCKS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Initial memory contents: a fixed scramble of the word address
    function automatic logic [127:0] dflt_line(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[w*32 +: 32] = 32'({la, 2'(w)}) * 32'h9E37_79B1 ^ 32'h5A5A_C3C3;
        end
        return l;
    endfunction

    // Memory device storage (used by the responder)
    logic [127:0] mem_store [logic [27:0]];
    // Reference model: what main memory holds and what each cache slot holds
    logic [127:0] ref_mem   [logic [27:0]];
    bit           ref_valid [8];
    bit           ref_dirty [8];
    logic [24:0]  ref_tag   [8];
    logic [127:0] ref_line  [8];

    function automatic logic [127:0] store_get(input logic [27:0] la);
        return mem_store.exists(la) ? mem_store[la] : dflt_line(la);
    endfunction

    function automatic logic [127:0] ref_get(input logic [27:0] la);
        return ref_mem.exists(la) ? ref_mem[la] : dflt_line(la);
    endfunction

    // Transaction log filled by the memory responder
    int unsigned  lat_log   [$];
    bit           kind_log  [$];
    logic [27:0]  addr_log  [$];
    logic [127:0] wdata_log [$];

    bit           mem_busy = 1'b0;
    int unsigned  mem_cnt  = 0;
    bit           cur_wr;
    logic [27:0]  cur_addr;
    logic [127:0] cur_wdata;

    // Memory responder: samples on negedge, random latency, one-cycle ready pulse.
    // An in-flight transaction always completes, even if the request was abandoned.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (bus.mem_read || bus.mem_write) begin
                check("mem_exclusive", 128'(bus.mem_read && bus.mem_write), 128'(0));
                if (!mem_busy) begin
                    mem_busy  = 1'b1;
                    cur_wr    = bus.mem_write;
                    cur_addr  = bus.mem_addr;
                    cur_wdata = bus.mem_wdata;
                    mem_cnt   = $urandom_range(1, 4);
                    lat_log.push_back(mem_cnt);
                    kind_log.push_back(cur_wr);
                    addr_log.push_back(cur_addr);
                    wdata_log.push_back(cur_wdata);
                end else begin
                    check("mem_hold_req", 128'({bus.mem_write, bus.mem_addr}), 128'({cur_wr, cur_addr}));
                    if (cur_wr) check("mem_hold_wdata", bus.mem_wdata, cur_wdata);
                end
            end
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_busy = 1'b0;
                    if (cur_wr) mem_store[cur_addr] = cur_wdata;
                    else        bus.mem_rdata = store_get(cur_addr);
                    bus.mem_ready = 1'b1;
                end
            end
        end
    end

    // One core access, called at posedge+1; returns at posedge+1 after completion
    // with the request still driven (so the next call is back-to-back).
    task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] wd);
        logic [2:0]   ix;
        logic [24:0]  tg;
        logic [1:0]   off;
        bit           hit;
        bit           wb;
        logic [27:0]  vaddr;
        logic [127:0] vline;
        logic [127:0] line_exp;
        int unsigned  stalls;
        int unsigned  exp_stalls;
        int unsigned  n_exp;
        bit           done;
        ix       = a[4:2];
        tg       = a[29:5];
        off      = a[1:0];
        hit      = ref_valid[ix] && (ref_tag[ix] == tg);
        wb       = !hit && ref_valid[ix] && ref_dirty[ix];
        vaddr    = {ref_tag[ix], ix};
        vline    = ref_line[ix];
        line_exp = hit ? ref_line[ix] : ref_get(a[29:2]);
        stalls   = 0;
        done     = 1'b0;
        lat_log.delete();
        kind_log.delete();
        addr_log.delete();
        wdata_log.delete();

        bus.proc_read  = !wr;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            #1;
            if (bus.proc_stall) stalls++;
            else begin
                done = 1'b1;
                if (!wr) check("rdata", 128'(bus.proc_rdata), 128'(line_exp[32*off +: 32]));
            end
        end
        check("access_done", 128'(done), 128'(1));

        n_exp = hit ? 0 : (wb ? 2 : 1);
        check("mem_txn_count", 128'(kind_log.size()), 128'(n_exp));
        if (kind_log.size() == n_exp && n_exp != 0) begin
            if (wb) begin
                check("wb_kind", 128'(kind_log[0]), 128'(1));
                check("wb_addr", 128'(addr_log[0]), 128'(vaddr));
                check("wb_data", wdata_log[0], vline);
            end
            check("fill_kind", 128'(kind_log[n_exp-1]), 128'(0));
            check("fill_addr", 128'(addr_log[n_exp-1]), 128'(a[29:2]));
        end
        exp_stalls = 0;
        if (!hit) begin
            foreach (lat_log[i]) exp_stalls += lat_log[i];
            exp_stalls += 1;
        end
        check("stall_cycles", 128'(stalls), 128'(exp_stalls));

        @(posedge clk);
        #1;
        if (!hit) begin
            if (wb) ref_mem[vaddr] = vline;
            ref_line[ix]  = ref_get(a[29:2]);
            ref_tag[ix]   = tg;
            ref_valid[ix] = 1'b1;
            ref_dirty[ix] = 1'b0;
        end
        if (wr) begin
            ref_line[ix][32*off +: 32] = wd;
            ref_dirty[ix] = 1'b1;
        end
    endtask

    task automatic idle(input int unsigned n);
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] pre;
        logic [24:0]  tg;
        bit           seen;
        rst_n          = 1'b0;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        foreach (ref_valid[i]) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = '0;
            ref_line[i]  = '0;
        end
        pre = {32'hDDDD_000D, 32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A};
        mem_store[28'h4] = pre;
        ref_mem[28'h4]   = pre;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_mem_read",  128'(bus.mem_read),  128'(0));
        check("rst_mem_write", 128'(bus.mem_write), 128'(0));
        check("rst_mem_addr",  128'(bus.mem_addr),  128'(0));
        check("rst_mem_wdata", bus.mem_wdata, 128'(0));
        check("rst_idle_stall", 128'(bus.proc_stall), 128'(0));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h10;
        #1;
        check("cold_req_stall", 128'(bus.proc_stall), 128'(1));

        // Directed: cold miss, hit, write hit, dirty eviction, write-miss allocate
        access(1'b0, 30'h000_0010, 32'h0);
        access(1'b0, 30'h000_0011, 32'h0);
        access(1'b1, 30'h000_0012, 32'hDEAD_BEEF);
        access(1'b0, 30'h000_0012, 32'h0);
        access(1'b0, 30'h000_0112, 32'h0);
        if (addr_log.size() == 2) begin
            check("evict_victim_addr", 128'(addr_log[0]), 128'(28'h4));
            check("evict_word2", 128'(wdata_log[0][95:64]), 128'(32'hDEAD_BEEF));
            check("evict_fill_addr", 128'(addr_log[1]), 128'(28'h44));
        end
        idle(1);
        access(1'b1, 30'h000_0020, 32'h1234_5678);
        access(1'b0, 30'h000_0020, 32'h0);

        // Reset while a refill is outstanding
        idle(1);
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h000_0018;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = bus.mem_read;
        end
        check("abort_req_seen", 128'(seen), 128'(1));
        rst_n = 1'b0;
        #1;
        check("abort_mem_read",  128'(bus.mem_read),  128'(0));
        check("abort_mem_write", 128'(bus.mem_write), 128'(0));
        bus.proc_read = 1'b0;
        foreach (ref_valid[i]) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 12 && (mem_busy || bus.mem_ready); c++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        check("stray_ready_mem_read", 128'(bus.mem_read), 128'(0));
        check("stray_ready_stall",    128'(bus.proc_stall), 128'(0));
        @(posedge clk);
        #1;
        access(1'b0, 30'h000_0018, 32'h0);
        access(1'b0, 30'h000_0020, 32'h0);

        // Random accesses over a small tag set so hits and evictions both occur
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       tg = 25'h0;
                1:       tg = 25'h1;
                2:       tg = 25'h2;
                default: tg = 25'h1FF_FFFF;
            endcase
            access(1'($urandom_range(0, 1)), {tg, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))}, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
